seq_wide_adder_ctrl: RTL and testbench
======================================

Name: seq_wide_adder_ctrl

Overview:
Sequencer that adds two wide operands by time-multiplexing one narrow ripple-carry adder slice across OP_W/SLICE_W cycles. The carry is chained between slices through a register. Operands are accepted and results returned over valid/ready handshakes. It sits between a requester (register file or test driver) and the shared adder slice datapath, trading area for latency.

Parameters:
OP_W, 16, operand and sum width in bits; must be an integer multiple of SLICE_W.
SLICE_W, 4, width of the ripple-carry slice used per cycle.
N_SLICE, OP_W/SLICE_W, derived localparam: number of slice cycles per operation (minimum 1).

Ports:
clk  input  1  rising-edge clock
reset_n  input  1  asynchronous active-low reset
valid_in  input  1  requester presents operands
ready_o  output  1  block can accept operands
a_in  input  OP_W  operand A
b_in  input  OP_W  operand B
c_in  input  1  carry-in to the least significant slice
valid_o  output  1  result available
ready_in  input  1  consumer accepts result
sum_o  output  OP_W  result sum
carry_o  output  1  carry-out of the most significant slice
busy_o  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync-released use): state=IDLE, ready_o=1, valid_o=0, busy_o=0, sum_o=0, carry_o=0, slice counter=0, carry register=0. Asserting reset mid-operation aborts it and discards the result.
- States: IDLE, RUN, DONE.
- IDLE: ready_o=1. On valid_in&&ready_o:
  - latch a_in, b_in into shift registers and c_in into the carry register
  - counter<=0, go to RUN.
- RUN: ready_o=0. Each cycle, the slice adds the low SLICE_W bits of the A/B shift registers plus the carry register.
  - On the edge: shift A/B right by SLICE_W; shift the slice sum into the top of the sum register (LSB slice ends at bits [SLICE_W-1:0]); carry register <= slice carry-out; counter++.
  - When counter==N_SLICE-1 on the edge: go to DONE and load carry_o.
- DONE: valid_o=1; sum_o and carry_o stable.
  - On valid_o&&ready_in: go to IDLE with valid_o=0 the next cycle.
  - If ready_in is held low, the result is held indefinitely.
- Latency: valid_o rises exactly N_SLICE edges after the accepting edge. Throughput: one op per N_SLICE+2 cycles (one IDLE bubble after handoff).
- valid_in while ready_o=0 is ignored; the requester must hold operands until accepted.
- Arithmetic is unsigned modulo 2^OP_W. carry_o is the true carry-out of bit OP_W-1. sum_o updates only on entering DONE; it keeps the last result in IDLE.
- N_SLICE==1: a single RUN cycle, so valid_o rises 1 edge after accept.

Optional Feature:
Macro SEQ_ADD_SUB_EN.
- Defined: adds input op_sub_in (1 bit), latched at accept. When set, B is bit-inverted at latch and the carry register is loaded with 1 (c_in ignored), giving sum_o=A-B mod 2^OP_W. carry_o=1 means no borrow.
- Undefined: the port is absent and the block performs addition only.

Decomposition:
- Package seq_add_pkg: state enum type (IDLE, RUN, DONE) and a default-width constant.
- Sub-module rca_slice: combinational SLICE_W-bit ripple-carry adder (a, b, cin -> sum, cout) built from per-bit full-adder logic. The controller instantiates exactly one.
- The counter width is $clog2(N_SLICE) with a floor of 1.

Test Plan:
1. Reset then A=0x1234, B=0x4321, c_in=0 -> valid_o after 4 edges; sum_o=0x5555, carry_o=0.
2. A=0xFFFF, B=0x0001, c_in=0 -> sum_o=0x0000, carry_o=1. This exercises carry propagation across all 4 slices.
3. A=0x000F, B=0x0000, c_in=1 -> sum_o=0x0010, carry_o=0. With ready_in held low 10 cycles: valid_o stays 1 and sum_o stays stable; ready_o=0 throughout.
4. Assert valid_in with new operands during RUN -> ignored. Result matches the first operands; the second op is accepted only once ready_o returns to 1.
5. Pull reset_n low in the second RUN cycle -> outputs immediately return to reset values. A subsequent 0x0002+0x0003 gives 0x0005.
6. With SEQ_ADD_SUB_EN, op_sub_in=1, A=0x0005, B=0x0007 -> sum_o=0xFFFE, carry_o=0. For A=0x0007, B=0x0005 -> sum_o=0x0002, carry_o=1.

Source files
------------

// File: rtl/seq_wide_adder_ctrl_pkg.sv
// Shared types and constants for the sequential wide adder.
// Optional build macro: SEQ_ADD_SUB_EN (adds subtract mode).
package seq_add_pkg;

  // Controller state encoding
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_add_state_t;

  // Default operand and slice widths
  localparam int DEFAULT_OP_W    = 16;
  localparam int DEFAULT_SLICE_W = 4;

  // Slice counter width: $clog2 of the slice count, never below one bit
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/seq_wide_adder_ctrl_if.sv
// Operand/result handshake bundle for seq_wide_adder_ctrl.
// Optional build macro: SEQ_ADD_SUB_EN adds the op_sub_in signal.
interface seq_wide_adder_ctrl_if #(
  parameter int OP_W = seq_add_pkg::DEFAULT_OP_W
);
  logic            valid_in;
  logic            ready_o;
  logic [OP_W-1:0] a_in;
  logic [OP_W-1:0] b_in;
  logic            c_in;
`ifdef SEQ_ADD_SUB_EN
  logic            op_sub_in;
`endif
  logic            valid_o;
  logic            ready_in;
  logic [OP_W-1:0] sum_o;
  logic            carry_o;
  logic            busy_o;

  // Adder side
  modport slave (
    input  valid_in, a_in, b_in, c_in, ready_in,
`ifdef SEQ_ADD_SUB_EN
    input  op_sub_in,
`endif
    output ready_o, valid_o, sum_o, carry_o, busy_o
  );

  // Requester / consumer side
  modport master (
    output valid_in, a_in, b_in, c_in, ready_in,
`ifdef SEQ_ADD_SUB_EN
    output op_sub_in,
`endif
    input  ready_o, valid_o, sum_o, carry_o, busy_o
  );
endinterface

// File: rtl/rca_slice.sv
// Combinational SLICE_W-bit ripple-carry adder built from full-adder bits.
module rca_slice #(
  parameter int SLICE_W = 4
) (
  input  logic [SLICE_W-1:0] a,
  input  logic [SLICE_W-1:0] b,
  input  logic               cin,
  output logic [SLICE_W-1:0] sum,
  output logic               cout
);
  logic [SLICE_W:0] carry;

  assign carry[0] = cin;

  // One full adder per bit, carries rippling upward
  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_fa
    assign sum[gi]     = a[gi] ^ b[gi] ^ carry[gi];
    assign carry[gi+1] = (a[gi] & b[gi]) | (carry[gi] & (a[gi] ^ b[gi]));
  end

  assign cout = carry[SLICE_W];
endmodule

// File: rtl/seq_wide_adder_ctrl.sv
// Sequential wide adder: one narrow ripple-carry slice reused over
// OP_W/SLICE_W cycles, carry chained through a register.
// Optional build macro: SEQ_ADD_SUB_EN (A-B via invert-and-add-one).
module seq_wide_adder_ctrl
  import seq_add_pkg::*;
#(
  parameter int OP_W    = DEFAULT_OP_W,
  parameter int SLICE_W = DEFAULT_SLICE_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  seq_wide_adder_ctrl_if.slave  bus
);
  localparam int N_SLICE = OP_W / SLICE_W;
  localparam int CNT_W   = cnt_width(N_SLICE);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_SLICE - 1);

  seq_add_state_t    state_reg;
  logic [OP_W-1:0]   a_sh_reg;
  logic [OP_W-1:0]   b_sh_reg;
  logic [OP_W-1:0]   sum_acc_reg;
  logic [OP_W-1:0]   sum_out_reg;
  logic              carry_reg;
  logic              carry_out_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic              ready_reg;
  logic              valid_reg;
  logic              busy_reg;

  logic [SLICE_W-1:0] slice_sum;
  logic               slice_cout;
  logic [OP_W-1:0]    sum_acc_next;

  // The single shared adder slice works on the low bits of the shifters
  rca_slice #(.SLICE_W(SLICE_W)) u_slice (
    .a    (a_sh_reg[SLICE_W-1:0]),
    .b    (b_sh_reg[SLICE_W-1:0]),
    .cin  (carry_reg),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  // Slice sums enter at the top so the first (LSB) slice ends at the bottom
  if (N_SLICE > 1) begin : g_multi
    assign sum_acc_next = {slice_sum, sum_acc_reg[OP_W-1:SLICE_W]};
  end else begin : g_single
    assign sum_acc_next = slice_sum;
  end

  // Controller FSM with registered handshake outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      a_sh_reg      <= '0;
      b_sh_reg      <= '0;
      sum_acc_reg   <= '0;
      sum_out_reg   <= '0;
      carry_reg     <= 1'b0;
      carry_out_reg <= 1'b0;
      cnt_reg       <= '0;
      ready_reg     <= 1'b1;
      valid_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.valid_in && ready_reg) begin
            a_sh_reg  <= bus.a_in;
`ifdef SEQ_ADD_SUB_EN
            // Subtract as A + ~B + 1; the +1 rides in on the carry
            b_sh_reg  <= bus.op_sub_in ? ~bus.b_in : bus.b_in;
            carry_reg <= bus.op_sub_in ? 1'b1 : bus.c_in;
`else
            b_sh_reg  <= bus.b_in;
            carry_reg <= bus.c_in;
`endif
            cnt_reg   <= '0;
            ready_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= RUN;
          end
        end
        RUN: begin
          a_sh_reg    <= a_sh_reg >> SLICE_W;
          b_sh_reg    <= b_sh_reg >> SLICE_W;
          sum_acc_reg <= sum_acc_next;
          carry_reg   <= slice_cout;
          cnt_reg     <= cnt_reg + CNT_W'(1);
          if (cnt_reg == LAST_CNT) begin
            // Result becomes visible only here; it persists through IDLE
            sum_out_reg   <= sum_acc_next;
            carry_out_reg <= slice_cout;
            valid_reg     <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (bus.ready_in) begin
            valid_reg <= 1'b0;
            ready_reg <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          ready_reg <= 1'b1;
          valid_reg <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.ready_o = ready_reg;
  assign bus.valid_o = valid_reg;
  assign bus.busy_o  = busy_reg;
  assign bus.sum_o   = sum_out_reg;
  assign bus.carry_o = carry_out_reg;

endmodule

// File: tb/tb_seq_wide_adder_ctrl.sv
// Self-checking bench for seq_wide_adder_ctrl: directed cases plus
// randomized operations against an arithmetic reference model.
module tb_seq_wide_adder_ctrl;
  localparam int OP_W    = 16;
  localparam int SLICE_W = 4;
  localparam int N_SLICE = OP_W / SLICE_W;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  seq_wide_adder_ctrl_if #(.OP_W(OP_W)) bus ();

  seq_wide_adder_ctrl #(.OP_W(OP_W), .SLICE_W(SLICE_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_ops    = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: {carry, sum} from plain wide arithmetic
  function automatic logic [OP_W:0] model(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b,
                                          input logic c, input logic sub);
    logic [OP_W:0] r;
    if (sub) r = {1'b0, a} + {1'b0, ~b} + (OP_W+1)'(1);
    else     r = {1'b0, a} + {1'b0, b} + (OP_W+1)'(c);
    return r;
  endfunction

  task automatic run_op(input logic [OP_W-1:0] a, input logic [OP_W-1:0] b, input logic c,
                        input logic sub_req, input int hold, input bit inject);
    logic [OP_W:0] exp;
    logic sub;
    int lat;
    bit got;
`ifdef SEQ_ADD_SUB_EN
    sub = sub_req;
`else
    sub = 1'b0;
`endif
    exp = model(a, b, c, sub);
    @(negedge clk);
    bus.a_in = a; bus.b_in = b; bus.c_in = c; bus.valid_in = 1'b1;
`ifdef SEQ_ADD_SUB_EN
    bus.op_sub_in = sub;
`endif
    got = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (bus.ready_o === 1'b1) begin got = 1'b1; break; end
      @(negedge clk);
    end
    check("accept_ready", {63'd0, got}, 64'd1);
    @(posedge clk); #1;
    bus.valid_in = 1'b0;
    check("run_ready_low", {63'd0, bus.ready_o}, 64'd0);
    check("run_busy", {63'd0, bus.busy_o}, 64'd1);
    if (inject) begin
      // Traffic while busy must be ignored
      bus.valid_in = 1'b1; bus.a_in = OP_W'($urandom); bus.b_in = OP_W'($urandom);
      bus.c_in = 1'($urandom);
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if (bus.valid_o === 1'b1) begin lat = i; break; end
    end
    bus.valid_in = 1'b0;
    check("latency", 64'(lat), 64'(N_SLICE));
    check("sum", 64'(bus.sum_o), 64'(exp[OP_W-1:0]));
    check("carry", {63'd0, bus.carry_o}, {63'd0, exp[OP_W]});
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {63'd0, bus.valid_o}, 64'd1);
      check("hold_sum", 64'(bus.sum_o), 64'(exp[OP_W-1:0]));
      check("hold_ready", {63'd0, bus.ready_o}, 64'd0);
    end
    @(negedge clk); bus.ready_in = 1'b1;
    @(posedge clk); #1; bus.ready_in = 1'b0;
    check("post_valid", {63'd0, bus.valid_o}, 64'd0);
    check("post_ready", {63'd0, bus.ready_o}, 64'd1);
    check("post_busy", {63'd0, bus.busy_o}, 64'd0);
    check("post_sum_kept", 64'(bus.sum_o), 64'(exp[OP_W-1:0]));
    n_ops++;
    $display("op %0d: a=0x%04h b=0x%04h c=%0d sub=%0d -> sum=0x%04h carry=%0d lat=%0d",
             n_ops, a, b, c, sub, bus.sum_o, bus.carry_o, lat);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, {63'd0, bus.ready_o}, 64'd1);
    check({tag, "_valid"}, {63'd0, bus.valid_o}, 64'd0);
    check({tag, "_busy"},  {63'd0, bus.busy_o},  64'd0);
    check({tag, "_sum"},   64'(bus.sum_o),       64'd0);
    check({tag, "_carry"}, {63'd0, bus.carry_o}, 64'd0);
  endtask

  initial begin
    bus.valid_in = 1'b0; bus.ready_in = 1'b0;
    bus.a_in = '0; bus.b_in = '0; bus.c_in = 1'b0;
`ifdef SEQ_ADD_SUB_EN
    bus.op_sub_in = 1'b0;
`endif
    #22;
    check_reset_values("reset");
    @(negedge clk); reset_n = 1'b1;

    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'hFFFF, 16'h0001, 1'b0, 1'b0, 0, 1'b0);
    run_op(16'h000F, 16'h0000, 1'b1, 1'b0, 10, 1'b0);
    run_op(16'h0100, 16'h0200, 1'b0, 1'b0, 1, 1'b1);

    // Abort in the second RUN cycle
    @(negedge clk);
    bus.a_in = 16'hAAAA; bus.b_in = 16'h5555; bus.c_in = 1'b1; bus.valid_in = 1'b1;
    @(posedge clk); #1; bus.valid_in = 1'b0;
    @(posedge clk); #1;
    reset_n = 1'b0;
    #1;
    check_reset_values("abort");
    @(negedge clk); reset_n = 1'b1;
    run_op(16'h0002, 16'h0003, 1'b0, 1'b0, 0, 1'b0);

`ifdef SEQ_ADD_SUB_EN
    run_op(16'h0005, 16'h0007, 1'b1, 1'b1, 0, 1'b0);
    run_op(16'h0007, 16'h0005, 1'b0, 1'b1, 0, 1'b0);
`endif

    for (int k = 0; k < 25; k++) begin
      run_op(OP_W'($urandom), OP_W'($urandom), 1'($urandom), 1'($urandom),
             int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Global guard so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
